// File: rtl/coef_pkg.sv
// Shared defaults, FSM state type and column-major index helpers for the
// coefficient matrix loader.
package coef_pkg;

  localparam int DEF_DATA_W = 14;
  localparam int DEF_ROWS   = 8;
  localparam int DEF_COLS   = 4;

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } load_state_e;

  // Word k of a column-major stream lands at row k%rows, column k/rows.
  function automatic int row_of(input int k, input int rows);
    return k % rows;
  endfunction

  function automatic int col_of(input int k, input int rows);
    return k / rows;
  endfunction

endpackage

// File: rtl/coef_bank.sv
// One ROWS x COLS coefficient register bank: single word write port and a
// combinational whole-column read (out-of-range columns read as zero).
module coef_bank
  import coef_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ROW_W-1:0]       wr_row,
  input  logic [COL_W-1:0]       wr_col,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [COL_W-1:0]       rd_col,
  output logic [ROWS*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [COLS][ROWS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < COLS; c++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem[c][r] <= '0;
        end
      end
    end else if (we) begin
      for (int c = 0; c < COLS; c++) begin
        for (int r = 0; r < ROWS; r++) begin
          if (wr_col == COL_W'(c) && wr_row == ROW_W'(r)) begin
            mem[c][r] <= wr_data;
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < COLS; c++) begin
      if (rd_col == COL_W'(c)) begin
        for (int r = 0; r < ROWS; r++) begin
          rd_data[r*DATA_W +: DATA_W] = mem[c][r];
        end
      end
    end
  end

endmodule

// File: rtl/coef_matrix_loader.sv
// Double-buffered coefficient matrix store: loads a column-major stream into
// the shadow bank, swaps on completion, serves whole columns with 1-cycle latency.
module coef_matrix_loader
  import coef_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int COL_W  = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int CNT_W  = $clog2(ROWS * COLS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  input  logic                   reload,
  input  logic                   rd_en,
  input  logic [COL_W-1:0]       rd_addr,
  output logic                   rd_valid,
  output logic [ROWS*DATA_W-1:0] rd_data,
  output logic                   load_done,
  output logic                   swap,
  output logic                   active_bank,
  output logic [CNT_W-1:0]       load_count
);

  localparam int TOTAL = ROWS * COLS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Handshake: a word transfers on any rising edge where in_valid && in_ready.
  // in_ready is decoded from registered state only, so it never depends on in_valid.
  load_state_e state, state_nxt;
  logic accept, last;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [ROWS*DATA_W-1:0] col0, col1;

  assign in_ready = (state == LOAD);
  assign accept   = in_valid && in_ready;
  assign last     = accept && (load_count == CNT_W'(TOTAL - 1));
  assign wr_row   = ROW_W'(row_of(int'(load_count), ROWS));
  assign wr_col   = COL_W'(col_of(int'(load_count), ROWS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  // reload wins over completion so a back-to-back reload restarts immediately.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (!reload && last) state_nxt = READY;
      READY:   if (reload) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_count  <= '0;
      active_bank <= 1'b0;
      load_done   <= 1'b0;
      swap        <= 1'b0;
    end else begin
      if (reload)      load_count <= '0;
      else if (accept) load_count <= load_count + 1'b1;
      swap        <= last;
      active_bank <= active_bank ^ last;
      load_done   <= load_done | last;
    end
  end

  // Writes always target the bank that is not currently serving reads.
  coef_bank #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) u_bank0 (
    .clk(clk), .rst(rst), .we(accept && active_bank),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(in_data),
    .rd_col(rd_addr), .rd_data(col0)
  );

  coef_bank #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) u_bank1 (
    .clk(clk), .rst(rst), .we(accept && !active_bank),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(in_data),
    .rd_col(rd_addr), .rd_data(col1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= active_bank ? col1 : col0;
    end
  end

endmodule

// File: tb/tb_coef_matrix_loader.sv
// Randomized bench for coef_matrix_loader against a flat-array matrix model.
module tb_coef_matrix_loader;

  localparam int DATA_W = 14;
  localparam int ROWS   = 8;
  localparam int COLS   = 4;
  localparam int COL_W  = 2;
  localparam int CNT_W  = 6;
  localparam int TOTAL  = ROWS * COLS;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic [DATA_W-1:0]      in_data;
  logic                   in_ready;
  logic                   reload;
  logic                   rd_en;
  logic [COL_W-1:0]       rd_addr;
  logic                   rd_valid;
  logic [ROWS*DATA_W-1:0] rd_data;
  logic                   load_done;
  logic                   swap;
  logic                   active_bank;
  logic [CNT_W-1:0]       load_count;

  int n_vec = 0;
  int n_err = 0;

  coef_matrix_loader #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .load_done(load_done),
    .swap(swap), .active_bank(active_bank), .load_count(load_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: each bank is a flat column-major word array
  logic [DATA_W-1:0]      mat [2][TOTAL];
  bit                     m_act, m_done, m_swap, m_loading, m_rd_valid;
  int                     m_count;
  logic [ROWS*DATA_W-1:0] m_rd;

  function automatic logic [ROWS*DATA_W-1:0] col_word(input bit b, input int c);
    logic [ROWS*DATA_W-1:0] w;
    w = '0;
    if (c < COLS) begin
      for (int r = 0; r < ROWS; r++) w[r*DATA_W +: DATA_W] = mat[b][c*ROWS + r];
    end
    return w;
  endfunction

  function automatic logic [ROWS*DATA_W-1:0] const_col(input int first);
    logic [ROWS*DATA_W-1:0] w;
    for (int r = 0; r < ROWS; r++) w[r*DATA_W +: DATA_W] = DATA_W'(first + r);
    return w;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < TOTAL; k++) mat[b][k] = '0;
    m_act = 0; m_done = 0; m_swap = 0; m_loading = 1; m_rd_valid = 0;
    m_count = 0; m_rd = '0;
  endtask

  // driver: apply one cycle of inputs and advance the model on the same edge
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit rl,
                      input bit re, input logic [COL_W-1:0] a);
    bit acc, fin;
    @(negedge clk);
    in_valid = v; in_data = d; reload = rl; rd_en = re; rd_addr = a;
    @(posedge clk);
    acc = m_loading && v;
    m_rd_valid = re;
    if (re) m_rd = col_word(m_act, int'(a));
    fin = acc && (m_count == TOTAL - 1);
    if (acc) mat[!m_act][m_count] = d;
    m_swap = fin;
    if (fin) begin m_act = !m_act; m_done = 1; m_loading = 0; end
    if (rl) begin m_count = 0; m_loading = 1; end
    else if (acc) m_count++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 0; in_data = '0; reload = 0; rd_en = 0; rd_addr = '0;
    model_reset();
    #12;
    n_vec++; if ({in_ready, rd_valid, load_done, swap, active_bank} !== 5'b10000) begin
      n_err++; $display("FAIL reset_flags got %b exp 10000", {in_ready, rd_valid, load_done, swap, active_bank}); end
    n_vec++; if (load_count !== '0) begin
      n_err++; $display("FAIL reset_count got %0d exp 0", load_count); end
    n_vec++; if (rd_data !== '0) begin
      n_err++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    @(negedge clk); rst = 1'b1;
    step(0, '0, 0, 1, 2'd2);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== '0) begin
      n_err++; $display("FAIL reset_read got v=%b d=%h exp v=1 d=0", rd_valid, rd_data); end
    n_vec++; if (load_done !== 1'b0 || active_bank !== 1'b0) begin
      n_err++; $display("FAIL reset_read_state got done=%b bank=%b exp 0 0", load_done, active_bank); end
  endtask

  task automatic test_full_load();
    int guard = 0;
    int swaps = 0;
    bit v, re;
    logic [COL_W-1:0] a;
    while (m_loading && guard < 200) begin
      v = ($urandom_range(0, 3) != 0);
      re = $urandom_range(0, 1);
      a = COL_W'($urandom_range(0, COLS - 1));
      step(v, DATA_W'(m_count + 1), 0, re, a);
      if (swap === 1'b1) swaps++;
      n_vec++; if (in_ready !== m_loading || load_count !== CNT_W'(m_count)) begin
        n_err++; $display("FAIL full_ctrl got rdy=%b cnt=%0d exp rdy=%b cnt=%0d", in_ready, load_count, m_loading, m_count); end
      n_vec++; if (swap !== m_swap || active_bank !== m_act || load_done !== m_done) begin
        n_err++; $display("FAIL full_swap got %b%b%b exp %b%b%b", swap, active_bank, load_done, m_swap, m_act, m_done); end
      n_vec++; if (rd_valid !== m_rd_valid || rd_data !== m_rd) begin
        n_err++; $display("FAIL full_read got v=%b d=%h exp v=%b d=%h", rd_valid, rd_data, m_rd_valid, m_rd); end
      guard++;
    end
    n_vec++; if (guard >= 200 || swaps != 1) begin
      n_err++; $display("FAIL full_done got guard=%0d swaps=%0d exp <200 and 1", guard, swaps); end
    step(0, '0, 0, 1, 2'd1);
    n_vec++; if (rd_data !== const_col(9)) begin
      n_err++; $display("FAIL full_col1 got %h exp %h", rd_data, const_col(9)); end
    n_vec++; if (in_ready !== 1'b0 || active_bank !== 1'b1 || load_done !== 1'b1) begin
      n_err++; $display("FAIL full_after got rdy=%b bank=%b done=%b exp 0 1 1", in_ready, active_bank, load_done); end
  endtask

  task automatic test_overlap_read();
    int guard = 0;
    bit pre_act;
    step(0, '0, 1, 1, 2'd0);
    while (m_loading && guard < 100) begin
      pre_act = m_act;
      step(1, DATA_W'(101 + m_count), 0, 1, 2'd0);
      n_vec++; if (rd_data !== m_rd || (pre_act && rd_data !== const_col(1))) begin
        n_err++; $display("FAIL overlap_read got %h exp %h", rd_data, m_rd); end
      n_vec++; if (load_count !== CNT_W'(m_count) || swap !== m_swap) begin
        n_err++; $display("FAIL overlap_ctrl got cnt=%0d swap=%b exp %0d %b", load_count, swap, m_count, m_swap); end
      guard++;
    end
    n_vec++; if (guard != TOTAL) begin
      n_err++; $display("FAIL overlap_len got %0d exp %0d", guard, TOTAL); end
    step(0, '0, 0, 1, 2'd0);
    n_vec++; if (rd_data !== const_col(101)) begin
      n_err++; $display("FAIL overlap_new got %h exp %h", rd_data, const_col(101)); end
  endtask

  task automatic test_abort();
    int guard = 0;
    step(0, '0, 1, 0, '0);
    for (int i = 0; i < 10; i++) step(1, DATA_W'($urandom), 0, 0, '0);
    n_vec++; if (load_count !== CNT_W'(10) || swap !== 1'b0) begin
      n_err++; $display("FAIL abort_partial got cnt=%0d swap=%b exp 10 0", load_count, swap); end
    step(0, '0, 1, 0, '0);
    n_vec++; if (load_count !== '0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_restart got cnt=%0d rdy=%b exp 0 1", load_count, in_ready); end
    while (m_loading && guard < 100) begin
      step(1, DATA_W'(201 + m_count), 0, 0, '0);
      n_vec++; if (load_count !== CNT_W'(m_count) || swap !== m_swap) begin
        n_err++; $display("FAIL abort_stream got cnt=%0d swap=%b exp %0d %b", load_count, swap, m_count, m_swap); end
      guard++;
    end
    n_vec++; if (guard != TOTAL || load_count !== CNT_W'(TOTAL)) begin
      n_err++; $display("FAIL abort_len got %0d cnt=%0d exp %0d", guard, load_count, TOTAL); end
    step(0, '0, 0, 1, 2'd3);
    n_vec++; if (rd_data !== const_col(225)) begin
      n_err++; $display("FAIL abort_col3 got %h exp %h", rd_data, const_col(225)); end
  endtask

  task automatic test_reload_final();
    step(0, '0, 1, 0, '0);
    for (int i = 0; i < TOTAL - 1; i++) step(1, DATA_W'($urandom), 0, 0, '0);
    step(1, DATA_W'($urandom), 1, 0, '0);
    n_vec++; if (swap !== 1'b1 || in_ready !== 1'b1 || load_count !== '0) begin
      n_err++; $display("FAIL reload_final got swap=%b rdy=%b cnt=%0d exp 1 1 0", swap, in_ready, load_count); end
    n_vec++; if (active_bank !== m_act) begin
      n_err++; $display("FAIL reload_final_bank got %b exp %b", active_bank, m_act); end
    step(0, '0, 0, 1, COL_W'($urandom_range(0, COLS - 1)));
    n_vec++; if (rd_data !== m_rd || swap !== 1'b0) begin
      n_err++; $display("FAIL reload_final_read got %h swap=%b exp %h 0", rd_data, swap, m_rd); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1, DATA_W'($urandom), 0, 1, 2'd1);
    @(negedge clk); in_valid = 0; rd_en = 0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_vec++; if ({in_ready, rd_valid, load_done, swap, active_bank} !== 5'b10000 || load_count !== '0) begin
      n_err++; $display("FAIL async_reset got %b cnt=%0d exp 10000 0", {in_ready, rd_valid, load_done, swap, active_bank}, load_count); end
    n_vec++; if (rd_data !== '0) begin
      n_err++; $display("FAIL async_reset_data got %h exp 0", rd_data); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step(0, '0, 0, 1, 2'd1);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== '0) begin
      n_err++; $display("FAIL async_reset_read got v=%b d=%h exp 1 0", rd_valid, rd_data); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), DATA_W'($urandom), ($urandom_range(0, 39) == 0),
           $urandom_range(0, 1), COL_W'($urandom_range(0, COLS - 1)));
      n_vec++; if (in_ready !== m_loading || load_count !== CNT_W'(m_count) ||
                   swap !== m_swap || active_bank !== m_act || load_done !== m_done) begin
        n_err++; $display("FAIL random_ctrl cyc %0d got %b%b%b%b cnt=%0d exp %b%b%b%b cnt=%0d", i,
                          in_ready, swap, active_bank, load_done, load_count,
                          m_loading, m_swap, m_act, m_done, m_count); end
      n_vec++; if (rd_valid !== m_rd_valid || rd_data !== m_rd) begin
        n_err++; $display("FAIL random_read cyc %0d got v=%b d=%h exp v=%b d=%h", i, rd_valid, rd_data, m_rd_valid, m_rd); end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_overlap_read();
    test_abort();
    test_reload_final();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
